fpu_issue_ctl: RTL

IU-side sequencer that sits directly upstream of the FPU top level and downstream of the IU decode/operand read.
- Accepts one FP operation request per transaction and drives the FPU opcode/operand buses.
- Transfers double-precision operands as two 32-bit beats (hi word first).
- Tracks the FPU busy handshake and collects the 32-bit or 64-bit result into a held result register.
- Propagates IU hold and kill to the FPU.

---
 rtl/fpu_issue_pkg.sv | 23 ++
 rtl/fpu_issue_wdog.sv | 30 +++
 rtl/fpu_issue_ctl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue sequencer.
package fpu_issue_pkg;

  localparam int FP_WORD_W = 32;
  localparam int FP_OP_W   = 8;

  // Default watchdog limit in WAIT cycles. It is only used when the design
  // is built with FPU_WATCHDOG_EN defined.
  localparam int TIMEOUT_CYC_DFLT = 1023;
  // Default number of cycles after the last operand beat during which the
  // FPU may still drop fpbusyn.
  localparam int BUSY_LAT_DFLT    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_OPND2,
    S_WAIT,
    S_RES2,
    S_DONE
  } state_e;

endpackage

// File: rtl/fpu_issue_wdog.sv
// WAIT-state watchdog: counts un-held WAIT cycles and flags the cycle that
// reaches the limit. It is instantiated only when FPU_WATCHDOG_EN is defined.
module fpu_issue_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset_l,
  input  logic run,      // in WAIT and not held
  input  logic clr,      // outside WAIT
  output logic expired   // this run cycle is the TIMEOUT_CYC-th one
);

  localparam logic [9:0] LAST = 10'(TIMEOUT_CYC - 1);

  logic [9:0] cnt;

  assign expired = run && (cnt == LAST);

  // Count un-held WAIT cycles and restart whenever WAIT is left.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/fpu_issue_ctl.sv
// IU-side FPU issue sequencer. It takes one FP request, drives the opcode and
// operand beats to the FPU (hi word first), waits on the fpbusyn handshake and
// holds the collected result until the IU consumes it.
// Optional build macro: FPU_WATCHDOG_EN enables the WAIT-state watchdog and
// the res_timeout flag.
module fpu_issue_ctl
  import fpu_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
  parameter int unsigned BUSY_LAT    = BUSY_LAT_DFLT
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [FP_OP_W-1:0]   req_op,
  input  logic                 req_dsrc,
  input  logic                 req_dres,
  input  logic [FP_WORD_W-1:0] req_a_hi,
  input  logic [FP_WORD_W-1:0] req_a_lo,
  input  logic [FP_WORD_W-1:0] req_b_hi,
  input  logic [FP_WORD_W-1:0] req_b_lo,
  input  logic                 iu_hold,
  input  logic                 iu_kill,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FP_WORD_W-1:0] res_hi,
  output logic [FP_WORD_W-1:0] res_lo,
  output logic                 res_timeout,
  output logic [FP_OP_W-1:0]   fpop,
  output logic                 fpop_valid,
  output logic [FP_WORD_W-1:0] fpain,
  output logic [FP_WORD_W-1:0] fpbin,
  output logic                 fphold,
  output logic                 fpkill,
  input  logic [FP_WORD_W-1:0] fpout,
  input  logic                 fpbusyn
);

  localparam int LAT_W = (BUSY_LAT < 1) ? 1 : $clog2(BUSY_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(BUSY_LAT);

  state_e               state;
  logic                 dsrc_q;
  logic                 dres_q;
  logic [FP_WORD_W-1:0] a_lo_q;
  logic [FP_WORD_W-1:0] b_lo_q;
  logic                 busy_seen;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 lat_done;

  // A stalled IU must not see ready, otherwise a request offered during hold
  // would be dropped while the state is frozen.
  assign req_ready = (state == S_IDLE) && !iu_hold;
  assign fphold    = iu_hold;
  assign lat_done  = (lat_cnt == LAT_MAX);

`ifdef FPU_WATCHDOG_EN
  logic wdog_expired;
  logic timeout_q;

  fpu_issue_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .reset_l (reset_l),
    .run     ((state == S_WAIT) && !iu_hold),
    .clr     (state != S_WAIT),
    .expired (wdog_expired)
  );

  assign res_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign res_timeout        = 1'b0;
`endif

  // Sequencer FSM with registered FPU-side and IU-side outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      dsrc_q     <= 1'b0;
      dres_q     <= 1'b0;
      a_lo_q     <= '0;
      b_lo_q     <= '0;
      busy_seen  <= 1'b0;
      lat_cnt    <= '0;
      res_valid  <= 1'b0;
      res_hi     <= '0;
      res_lo     <= '0;
      fpop       <= '0;
      fpop_valid <= 1'b0;
      fpain      <= '0;
      fpbin      <= '0;
      fpkill     <= 1'b0;
`ifdef FPU_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the pre-edge values; the default below makes fpkill a pulse.
      fpkill <= 1'b0;
      if (iu_kill && (state != S_IDLE)) begin
        state      <= S_IDLE;
        fpkill     <= 1'b1;
        busy_seen  <= 1'b0;
        lat_cnt    <= '0;
        res_valid  <= 1'b0;
        fpop_valid <= 1'b0;
`ifdef FPU_WATCHDOG_EN
        timeout_q  <= 1'b0;
`endif
      end else begin
        // The busy indication is tracked even while held so that a short busy
        // pulse hidden inside a hold window is not lost.
        if ((state == S_WAIT) && !fpbusyn) busy_seen <= 1'b1;
        if (!iu_hold) begin
          case (state)
            S_IDLE: begin
              if (req_valid) begin
                fpop       <= req_op;
                fpop_valid <= 1'b1;
                fpain      <= req_a_hi;
                fpbin      <= req_b_hi;
                a_lo_q     <= req_a_lo;
                b_lo_q     <= req_b_lo;
                dsrc_q     <= req_dsrc;
                dres_q     <= req_dres;
                busy_seen  <= 1'b0;
                lat_cnt    <= '0;
                state      <= S_ISSUE;
              end
            end
            S_ISSUE: begin
              fpop_valid <= 1'b0;
              if (dsrc_q) begin
                fpain <= a_lo_q;
                fpbin <= b_lo_q;
                state <= S_OPND2;
              end else begin
                state <= S_WAIT;
              end
            end
            S_OPND2: state <= S_WAIT;
            S_WAIT: begin
              if (fpbusyn && (busy_seen || lat_done)) begin
                res_hi    <= fpout;
                res_lo    <= '0;
                res_valid <= !dres_q;
                state     <= dres_q ? S_RES2 : S_DONE;
              end else begin
                if (!lat_done) lat_cnt <= lat_cnt + 1'b1;
`ifdef FPU_WATCHDOG_EN
                if (wdog_expired) begin
                  fpkill    <= 1'b1;
                  timeout_q <= 1'b1;
                  res_hi    <= '0;
                  res_lo    <= '0;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
                end
`endif
              end
            end
            S_RES2: begin
              res_lo    <= fpout;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
            S_DONE: begin
              if (res_ready) begin
                res_valid <= 1'b0;
`ifdef FPU_WATCHDOG_EN
                timeout_q <= 1'b0;
`endif
                state     <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule
